// File: rtl/pc_unit.sv
// Program counter with hardware return-address stack.
// Tracks run / wait / halt; halt and error flags are sticky until reset.
module pc_unit #(
  parameter int              W_PC        = 16,
  parameter int              STACK_DEPTH = 8,
  parameter logic [W_PC-1:0] RESET_PC    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           step_i,
  input  logic [1:0]                     mode_pc_i,
  input  logic                           halt_core_i,
  input  logic                           wfi_core_i,
  input  logic [W_PC-1:0]                rel_off_i,
  input  logic [W_PC-1:0]                sbr_addr_i,
  output logic [W_PC-1:0]                pc_o,
  output logic [$clog2(STACK_DEPTH):0]   depth_o,
  output logic [1:0]                     state_o,
  output logic [1:0]                     err_o
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_RET = 2'd0,
    M_INC = 2'd1,
    M_REL = 2'd2,
    M_SBR = 2'd3
  } mode_t;

  state_t          state_q, state_d;
  logic [W_PC-1:0] pc_q, pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [1:0]      err_q, err_d;
  logic            exec;
  logic            push;
  logic            full;
  logic            empty;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   top_idx;
  logic [W_PC-1:0] ret_addr;
  logic [W_PC-1:0] stack_q [STACK_DEPTH];

  assign full     = (depth_q == FULL);
  assign empty    = (depth_q == '0);
  assign wr_idx   = depth_q[AW-1:0];
  assign top_idx  = depth_q[AW-1:0] - AW'(1);
  assign ret_addr = pc_q + W_PC'(1);

  // Next-state: run/wait/halt sequencing, then the PC mode action.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    exec    = 1'b0;
    push    = 1'b0;
    if (step_i) begin
      unique case (state_q)
        S_RUN: begin
          if (halt_core_i)     state_d = S_HALT;
          else if (wfi_core_i) state_d = S_WAIT;
          else                 exec    = 1'b1;
        end
        S_WAIT: begin
          if (halt_core_i) begin
            state_d = S_HALT;
          end else if (!wfi_core_i) begin
            state_d = S_RUN;
            exec    = 1'b1;
          end
        end
        S_HALT: ;
        default: state_d = S_HALT;
      endcase
    end
    if (exec) begin
      unique case (mode_pc_i)
        M_INC: pc_d = pc_q + W_PC'(1);
        M_REL: pc_d = pc_q + rel_off_i;
        M_SBR: begin
          if (full) begin
            err_d[0] = 1'b1;
            state_d  = S_HALT;
          end else begin
            push    = 1'b1;
            pc_d    = sbr_addr_i;
            depth_d = depth_q + DW'(1);
          end
        end
        M_RET: begin
          if (empty) begin
            err_d[1] = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Control and PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      depth_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) stack_q[wr_idx] <= ret_addr;
  end

  assign pc_o    = pc_q;
  assign depth_o = depth_q;
  assign state_o = state_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed plan plus random steps
// against a queue-based reference model.
module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        step_i = 1'b0;
  logic [1:0]  mode_pc_i = 2'd1;
  logic        halt_core_i = 1'b0;
  logic        wfi_core_i = 1'b0;
  logic [15:0] rel_off_i = '0;
  logic [15:0] sbr_addr_i = '0;
  logic [15:0] pc_o;
  logic [3:0]  depth_o;
  logic [1:0]  state_o;
  logic [1:0]  err_o;

  pc_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(step_i),
    .mode_pc_i(mode_pc_i), .halt_core_i(halt_core_i),
    .wfi_core_i(wfi_core_i), .rel_off_i(rel_off_i),
    .sbr_addr_i(sbr_addr_i), .pc_o(pc_o), .depth_o(depth_o),
    .state_o(state_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int unsigned m_pc;
  int          m_st;
  bit [1:0]    m_err;
  int unsigned m_stk[$];

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_st = 0;
    m_err = 0;
    m_stk.delete();
  endfunction

  function automatic void model_step();
    if (!step_i || m_st == 2) return;
    if (halt_core_i) begin m_st = 2; return; end
    if (wfi_core_i) begin m_st = 1; return; end
    m_st = 0;
    case (mode_pc_i)
      2'd1: m_pc = (m_pc + 1) % 65536;
      2'd2: m_pc = (m_pc + rel_off_i) % 65536;
      2'd3: begin
        if (m_stk.size() == 8) begin
          m_err[0] = 1'b1;
          m_st = 2;
        end else begin
          m_stk.push_back((m_pc + 1) % 65536);
          m_pc = sbr_addr_i;
        end
      end
      default: begin
        if (m_stk.size() == 0) begin
          m_err[1] = 1'b1;
          m_st = 2;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
    endcase
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("pc", pc_o, m_pc);
      check("depth", depth_o, m_stk.size());
      check("state", state_o, m_st);
      check("err", err_o, m_err);
    end
  end

  task automatic cyc(bit s, int md, bit h, bit w,
                     int unsigned off, int unsigned adr);
    step_i = s;
    mode_pc_i = 2'(md);
    halt_core_i = h;
    wfi_core_i = w;
    rel_off_i = 16'(off);
    sbr_addr_i = 16'(adr);
    @(posedge clk_i);
    if (rst_ni) model_step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("rst_async_pc", pc_o, 0);
    check("rst_async_state", state_o, 0);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    @(negedge clk_i);
    #1;
    check("reset_pc", pc_o, 0);
    check("reset_depth", depth_o, 0);
    check("reset_state", state_o, 0);
    check("reset_err", err_o, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      check("inc_pc", pc_o, i + 1);
    end
    check("inc_depth", depth_o, 0);
    check("inc_state", state_o, 0);

    cyc(0, 1, 0, 0, 0, 0);
    check("nostep_hold", pc_o, 3);

    cyc(1, 2, 0, 0, 16'h000D, 0);
    check("rel_to_10", pc_o, 16'h0010);
    cyc(1, 2, 0, 0, 16'hFFFC, 0);
    check("rel_neg", pc_o, 16'h000C);
    cyc(1, 2, 0, 0, 16'hFFF2, 0);
    check("rel_to_fffe", pc_o, 16'hFFFE);
    cyc(1, 2, 0, 0, 16'h0004, 0);
    check("rel_wrap", pc_o, 16'h0002);
    cyc(1, 2, 0, 0, 16'h0000, 0);
    check("rel_zero", pc_o, 16'h0002);

    cyc(1, 2, 0, 0, 3, 0);
    cyc(1, 3, 0, 0, 0, 16'h0100);
    check("call_pc", pc_o, 16'h0100);
    check("call_depth", depth_o, 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("ret_pc", pc_o, 6);
    check("ret_depth", depth_o, 0);

    for (int i = 0; i < 8; i++) cyc(1, 3, 0, 0, 0, 16'h1000 + i * 16);
    check("nest_depth", depth_o, 8);
    check("nest_pc", pc_o, 16'h1070);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0);
    check("unnest_pc", pc_o, 7);
    check("unnest_depth", depth_o, 0);

    for (int i = 0; i < 8; i++) cyc(1, 3, 0, 0, 0, 16'h2000 + i);
    cyc(1, 3, 0, 0, 0, 16'h3000);
    check("ovf_pc", pc_o, 16'h2007);
    check("ovf_err", err_o, 1);
    check("ovf_state", state_o, 2);
    check("ovf_depth", depth_o, 8);
    for (int i = 0; i < 6; i++) cyc(1, i % 4, i % 2, 0, 5, 16'h4000);
    check("halt_frozen_pc", pc_o, 16'h2007);
    do_reset();
    check("post_rst_pc", pc_o, 0);
    check("post_rst_err", err_o, 0);

    cyc(1, 0, 0, 0, 0, 0);
    check("udf_err", err_o, 2);
    check("udf_state", state_o, 2);
    check("udf_pc", pc_o, 0);
    do_reset();

    cyc(1, 3, 0, 0, 0, 16'h0040);
    cyc(1, 3, 0, 0, 0, 16'h0080);
    cyc(1, 0, 1, 0, 0, 0);
    check("halt_state", state_o, 2);
    check("halt_depth", depth_o, 2);
    check("halt_pc", pc_o, 16'h0080);
    do_reset();

    cyc(1, 2, 0, 0, 9, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 1, 0, 0);
      check("wait_pc", pc_o, 9);
      check("wait_state", state_o, 1);
    end
    cyc(1, 1, 0, 0, 0, 0);
    check("wake_pc", pc_o, 10);
    check("wake_state", state_o, 0);
    cyc(1, 1, 0, 1, 0, 0);
    check("wait2_state", state_o, 1);
    do_reset();
    check("rst_wait_depth", depth_o, 0);

    for (int n = 0; n < 3000; n++) begin
      int md;
      md = int'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, md,
          $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
          ($urandom_range(0, 1) != 0) ? $urandom_range(0, 65535)
                                      : $urandom_range(0, 7),
          $urandom_range(0, 65535));
      if ((m_st == 2 && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 299) == 0)
        do_reset();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the opcode decoder.
- Consumes the decoder's PC mode, halt and wait-for-interrupt outputs, and produces the instruction-fetch address.
- Holds a hardware return-address stack for subroutine call (JSBR) and return (RSBR).
- Tracks core run / wait / halt state; halt is sticky until reset.

Parameters:
- W_PC, 16: PC and address width in bits.
- STACK_DEPTH, 8: return-stack entries; power of two, ≥2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- step_i  in  1  instruction retire strobe; PC state changes only when high.
- mode_pc_i  in  2  from decoder: 0 RETURN, 1 INCREMENT, 2 RELATIVE, 3 SUBROUTINE.
- halt_core_i  in  1  decoder halt request.
- wfi_core_i  in  1  decoder wait request; high while external interrupt absent.
- rel_off_i  in  W_PC  two's-complement branch offset.
- sbr_addr_i  in  W_PC  absolute subroutine target.
- pc_o  out  W_PC  current fetch address.
- depth_o  out  $clog2(STACK_DEPTH)+1  valid return-stack entries.
- state_o  out  2  0 RUN, 1 WAIT, 2 HALT.
- err_o  out  2  sticky: bit0 stack overflow, bit1 stack underflow.

Behaviour:
- Reset (rst_ni low, async): pc_o=RESET_PC, depth_o=0, state_o=RUN, err_o=0, stack contents don't-care. Release is synchronous to clk_i.
- All outputs are registered; a change in any input shows on the outputs one cycle after the step_i edge that samples it.
- step_i low: all state holds in every state.
- RUN with step_i high, evaluated in this priority order:
  1. halt_core_i=1 → state HALT, PC held. Halt overrides mode_pc_i, because the decoder drives RETURN on halt.
  2. wfi_core_i=1 → state WAIT, PC held.
  3. mode_pc_i=INCREMENT → pc+1.
  4. mode_pc_i=RELATIVE → pc+rel_off_i.
  5. mode_pc_i=SUBROUTINE → push pc+1, pc=sbr_addr_i, depth+1.
  6. mode_pc_i=RETURN → pc=top of stack, depth−1.
- WAIT with step_i high:
  - wfi_core_i still high → hold.
  - wfi_core_i low → execute mode_pc_i per the RUN rules (normally INCREMENT) and return to RUN.
  - halt_core_i high → HALT.
- HALT: absorbing; only rst_ni exits. Inputs ignored, pc_o and depth_o frozen.
- Arithmetic: all PC sums are modulo 2^W_PC.
  - RESET_PC = all-ones with INCREMENT gives 0.
  - Negative offsets wrap.
  - Offset 0 gives a self-loop and is legal.
  - Pushed pc+1 wraps the same way.
- Stack: LIFO; write pointer equals depth.
  - Push when depth=STACK_DEPTH → no push, no jump, err_o[0]=1, state HALT.
  - Pop when depth=0 → PC held, err_o[1]=1, state HALT.
  - Push to the last free slot (depth STACK_DEPTH−1→STACK_DEPTH) is legal.
  - Pop of the last entry (depth 1→0) is legal.
- err_o bits are set only by the conditions above and cleared only by reset.
- Reset asserted mid-WAIT or mid-HALT returns to RUN at RESET_PC with the stack emptied.
- No combinational path from any input to any output.

Test Plan:
- Reset then 3 steps of INCREMENT, RESET_PC=0 → pc_o 1,2,3; state_o=0; depth_o=0.
- pc=0x0010, RELATIVE with rel_off_i=0xFFFC → pc=0x000C. Then RELATIVE with 0x0004 at pc=0xFFFE → pc=0x0002.
- pc=5, SUBROUTINE sbr_addr_i=0x0100 → pc=0x0100, depth 1. Then INCREMENT ×2, then RETURN → pc=6, depth 0. Nested calls to depth 8 return in LIFO order.
- 8 calls, then a 9th SUBROUTINE → pc unchanged, err_o=01, state_o=2. Further steps and mode changes → nothing changes until rst_ni pulse, which gives pc=0, err_o=0.
- From reset, RETURN → err_o=10, state HALT, pc=0. Also HALT with mode_pc_i=RETURN and depth 2 → HALT, depth stays 2, no pop.
- wfi_core_i high for 5 steps at pc=9 → state WAIT, pc 9 throughout. Then wfi_core_i low with INCREMENT → pc=10, state RUN. rst_ni asserted mid-WAIT → RUN, pc=0, async within the same cycle.
